// File: rtl/canonical_huffman_decoder.sv
// Canonical Huffman decoder: loads a code-size list and a matching sorted symbol
// list, rebuilds the per-length code counts, then decodes an MSB-first bitstream
// into symbol IDs over valid/ready handshakes on both sides.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | nothing loaded, all outputs low
// BUILD   | walking the captured table, one entry per cycle
// DECODE  | accepting code bits, extending the partial code
// EMIT    | presenting a decoded symbol until downstream takes it
// ERROR   | bad table or undecodable code; sticky until load/reset
module canonical_huffman_decoder #(
  parameter int SYMBOLS         = 16,
  parameter int CODE_SIZE_WIDTH = 5,
  parameter int SYMBOL_ID_WIDTH = 5,
  parameter int MAX_CODE_LEN    = 15
) (
  input  logic                                 clk,
  input  logic                                 reset_n,
  input  logic                                 load,
  input  logic [SYMBOLS*CODE_SIZE_WIDTH-1:0]   code_size_array,
  input  logic [SYMBOLS*SYMBOL_ID_WIDTH-1:0]   sorted_symbols,
  input  logic                                 bit_in,
  input  logic                                 bit_valid,
  output logic                                 bit_ready,
  output logic [SYMBOL_ID_WIDTH-1:0]           sym_out,
  output logic                                 sym_valid,
  input  logic                                 sym_ready,
  output logic                                 table_ready,
  output logic                                 err
);

  // code/first carry one bit of headroom over the longest code
  localparam int CW   = MAX_CODE_LEN + 1;
  localparam int EW   = $clog2(SYMBOLS);
  localparam int CNTW = $clog2(SYMBOLS + 1);
  localparam int LW   = $clog2(MAX_CODE_LEN + 1);

  localparam logic [EW-1:0]              LAST_K   = EW'(SYMBOLS - 1);
  localparam logic [CNTW-1:0]            ALL_ZERO = CNTW'(SYMBOLS);
  localparam logic [LW-1:0]              MAX_LEN  = LW'(MAX_CODE_LEN);
  localparam logic [CODE_SIZE_WIDTH-1:0] MAX_SIZE = CODE_SIZE_WIDTH'(MAX_CODE_LEN);

  typedef enum logic [2:0] {
    S_IDLE,
    S_BUILD,
    S_DECODE,
    S_EMIT,
    S_ERROR
  } state_t;

  state_t state_q, state_d;

  logic [CODE_SIZE_WIDTH-1:0] size_q    [SYMBOLS];
  logic [SYMBOL_ID_WIDTH-1:0] sym_tab_q [SYMBOLS];
  logic [CNTW-1:0]            count_q   [MAX_CODE_LEN+1];
  logic [CNTW-1:0]            zero_cnt_q;
  logic [EW-1:0]              build_k_q;
  logic                       build_err_q;

  logic [CW-2:0]              code_q;
  logic [CW-1:0]              first_q;
  logic [CNTW-1:0]            index_q;
  logic [LW-1:0]              len_q;
  logic [SYMBOL_ID_WIDTH-1:0] sym_reg_q;

  logic [CODE_SIZE_WIDTH-1:0] cur_size;
  logic                       size_zero;
  logic                       size_bad;
  logic [CNTW-1:0]            zero_cnt_inc;
  logic                       build_last;
  logic                       bit_accept;
  logic [CW-1:0]              code_ext;
  logic [CNTW-1:0]            count_len;
  logic [CW-1:0]              diff;
  logic                       hit;
  logic [EW-1:0]              entry_idx;
  logic                       decode_init;

  // Build-walk and decode-step arithmetic shared by the FSM and the datapath
  always_comb begin
    cur_size     = size_q[build_k_q];
    size_zero    = (cur_size == '0);
    size_bad     = (cur_size > MAX_SIZE);
    zero_cnt_inc = zero_cnt_q + CNTW'(size_zero);
    build_last   = (build_k_q == LAST_K);
    bit_accept   = bit_valid && (state_q == S_DECODE) && !load;
    code_ext     = {code_q, bit_in};
    count_len    = count_q[len_q];
    // code_ext never falls below first for a canonical prefix, so no wrap
    diff         = code_ext - first_q;
    hit          = (diff < CW'(count_len));
    entry_idx    = EW'(index_q + diff[CNTW-1:0]);
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Next-state and Moore outputs
  always_comb begin
    state_d     = state_q;
    bit_ready   = 1'b0;
    sym_valid   = 1'b0;
    sym_out     = '0;
    table_ready = 1'b0;
    err         = 1'b0;

    unique case (state_q)
      S_IDLE: ;
      S_BUILD: begin
        if (build_last) begin
          if (build_err_q || size_bad || (zero_cnt_inc == ALL_ZERO)) state_d = S_ERROR;
          else                                                        state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        bit_ready   = 1'b1;
        table_ready = 1'b1;
        if (bit_accept) begin
          if (hit)                    state_d = S_EMIT;
          else if (len_q == MAX_LEN)  state_d = S_ERROR;
        end
      end
      S_EMIT: begin
        sym_valid   = 1'b1;
        sym_out     = sym_reg_q;
        table_ready = 1'b1;
        if (sym_ready) state_d = S_DECODE;
      end
      S_ERROR: begin
        err = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    // load overrides everything, including a bit offered in the same cycle
    if (load) state_d = S_BUILD;
  end

  assign decode_init = (state_d == S_DECODE) && (state_q != S_DECODE);

  // Table capture, length counting and the decode working registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SYMBOLS; i++) begin
        size_q[i]    <= '0;
        sym_tab_q[i] <= '0;
      end
      for (int l = 0; l <= MAX_CODE_LEN; l++) count_q[l] <= '0;
      zero_cnt_q  <= '0;
      build_k_q   <= '0;
      build_err_q <= 1'b0;
      code_q      <= '0;
      first_q     <= '0;
      index_q     <= '0;
      len_q       <= '0;
      sym_reg_q   <= '0;
    end else if (load) begin
      for (int i = 0; i < SYMBOLS; i++) begin
        size_q[i]    <= code_size_array[SYMBOLS*CODE_SIZE_WIDTH-1-i*CODE_SIZE_WIDTH -: CODE_SIZE_WIDTH];
        sym_tab_q[i] <= sorted_symbols[SYMBOLS*SYMBOL_ID_WIDTH-1-i*SYMBOL_ID_WIDTH -: SYMBOL_ID_WIDTH];
      end
      for (int l = 0; l <= MAX_CODE_LEN; l++) count_q[l] <= '0;
      zero_cnt_q  <= '0;
      build_k_q   <= '0;
      build_err_q <= 1'b0;
      code_q      <= '0;
      first_q     <= '0;
      index_q     <= '0;
      len_q       <= '0;
      sym_reg_q   <= '0;
    end else begin
      if (state_q == S_BUILD) begin
        if (size_zero)     zero_cnt_q  <= zero_cnt_inc;
        else if (size_bad) build_err_q <= 1'b1;
        else               count_q[cur_size[LW-1:0]] <= count_q[cur_size[LW-1:0]] + CNTW'(1);
        build_k_q <= build_k_q + EW'(1);
      end

      if (decode_init) begin
        code_q  <= '0;
        first_q <= '0;
        // the final build cycle may still be bumping zero_cnt
        index_q <= (state_q == S_BUILD) ? zero_cnt_inc : zero_cnt_q;
        len_q   <= LW'(1);
      end else if (bit_accept) begin
        if (hit) begin
          sym_reg_q <= sym_tab_q[entry_idx];
        end else begin
          index_q <= index_q + count_len;
          first_q <= (first_q + CW'(count_len)) << 1;
          code_q  <= code_ext[CW-2:0];
          len_q   <= len_q + LW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_canonical_huffman_decoder.sv
// Directed bench for canonical_huffman_decoder: table-driven decode vectors,
// hand-written multi-cycle sequences, and a random stream checked against a
// software canonical encoder.
module tb_canonical_huffman_decoder;

  localparam int SYMBOLS = 16;
  localparam int CSW     = 5;
  localparam int SIW     = 5;

  logic                   clk = 1'b0;
  logic                   reset_n;
  logic                   load;
  logic [SYMBOLS*CSW-1:0] cs_arr;
  logic [SYMBOLS*SIW-1:0] sym_arr;
  logic                   bit_in;
  logic                   bit_valid;
  logic                   bit_ready;
  logic [SIW-1:0]         sym_out;
  logic                   sym_valid;
  logic                   sym_ready;
  logic                   table_ready;
  logic                   err;

  canonical_huffman_decoder dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .load            (load),
    .code_size_array (cs_arr),
    .sorted_symbols  (sym_arr),
    .bit_in          (bit_in),
    .bit_valid       (bit_valid),
    .bit_ready       (bit_ready),
    .sym_out         (sym_out),
    .sym_valid       (sym_valid),
    .sym_ready       (sym_ready),
    .table_ready     (table_ready),
    .err             (err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  int cur_sz [SYMBOLS];
  int cur_sy [SYMBOLS];
  int t1_sz  [SYMBOLS];
  int t1_sy  [SYMBOLS];
  int t3_sz  [SYMBOLS];
  int t3_sy  [SYMBOLS];
  int t6_sz  [SYMBOLS];
  int t6_sy  [SYMBOLS];

  // Pulse load with cur_sz/cur_sy; count negedges until table_ready or err
  task automatic do_load(output int cyc, output logic err1);
    @(negedge clk);
    for (int i = 0; i < SYMBOLS; i++) begin
      cs_arr[SYMBOLS*CSW-1-i*CSW -: CSW]  = CSW'(cur_sz[i]);
      sym_arr[SYMBOLS*SIW-1-i*SIW -: SIW] = SIW'(cur_sy[i]);
    end
    load = 1'b1;
    bit_valid = 1'b0;
    @(negedge clk);
    load = 1'b0;
    cyc  = 1;
    err1 = err;
    while (!table_ready && !err && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  typedef struct {
    int bv; int bi; int sr;   // inputs driven this step
    int br; int sv; int so; int tr;  // outputs expected before driving
  } vec_t;

  vec_t t1v [14];

  int   cyc;
  logic err1;

  int   mcode [32];
  int   mlen  [32];
  int   used  [$];
  int   exp_q [$];
  bit   bits  [$];

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    t1_sz = '{0,0,0,0,0,0,0,0,0,0,0,0,1,2,3,3};
    t1_sy = '{0,0,0,0,0,0,0,0,0,0,0,0,3,7,9,12};
    t3_sz = '{0,0,0,0,0,0,0,0,0,0,0,0,0,1,2,3};
    t3_sy = '{0,0,0,0,0,0,0,0,0,0,0,0,0,3,7,9};
    t6_sz = '{0,0,0,0,2,3,3,3,4,4,4,4,5,5,5,5};
    t6_sy = '{0,0,0,0,5,1,7,3,9,8,4,6,0,10,2,11};

    //          bv bi sr   br sv so tr
    t1v[0]  = '{1, 0, 1,   1, 0, 0, 1};
    t1v[1]  = '{1, 1, 1,   0, 1, 3, 1};
    t1v[2]  = '{1, 1, 1,   1, 0, 0, 1};
    t1v[3]  = '{1, 0, 1,   1, 0, 0, 1};
    t1v[4]  = '{1, 1, 1,   0, 1, 7, 1};
    t1v[5]  = '{1, 1, 1,   1, 0, 0, 1};
    t1v[6]  = '{1, 1, 1,   1, 0, 0, 1};
    t1v[7]  = '{1, 0, 1,   1, 0, 0, 1};
    t1v[8]  = '{1, 1, 1,   0, 1, 9, 1};
    t1v[9]  = '{1, 1, 1,   1, 0, 0, 1};
    t1v[10] = '{1, 1, 1,   1, 0, 0, 1};
    t1v[11] = '{1, 1, 1,   1, 0, 0, 1};
    t1v[12] = '{0, 0, 1,   0, 1, 12, 1};
    t1v[13] = '{0, 0, 1,   1, 0, 0, 1};

    // Reset: outputs drop asynchronously and stay low in IDLE
    reset_n = 1'b0; load = 1'b0; bit_in = 1'b0; bit_valid = 1'b0; sym_ready = 1'b0;
    cs_arr = '0; sym_arr = '0;
    #1;
    chk("rst_outputs", 32'({bit_ready, sym_valid, table_ready, err, sym_out}), 0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("idle_outputs", 32'({bit_ready, sym_valid, table_ready, err, sym_out}), 0);

    // T1: build latency and basic decode
    cur_sz = t1_sz; cur_sy = t1_sy;
    do_load(cyc, err1);
    chk("t1_build_cycles", 32'(cyc), 17);
    chk("t1_err", 32'(err), 0);
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      chk($sformatf("t1_bit_ready[%0d]", i),   32'(bit_ready),   t1v[i].br);
      chk($sformatf("t1_sym_valid[%0d]", i),   32'(sym_valid),   t1v[i].sv);
      chk($sformatf("t1_sym_out[%0d]", i),     32'(sym_out),     t1v[i].so);
      chk($sformatf("t1_table_ready[%0d]", i), 32'(table_ready), t1v[i].tr);
      bit_valid = (t1v[i].bv != 0);
      bit_in    = (t1v[i].bi != 0);
      sym_ready = (t1v[i].sr != 0);
    end

    // T2: backpressure on symbol 7 (code 10)
    @(negedge clk);
    sym_ready = 1'b0; bit_valid = 1'b1; bit_in = 1'b1;
    chk("t2_ready_first", 32'(bit_ready), 1);
    @(negedge clk);
    bit_in = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bit_valid = 1'b0;
      chk($sformatf("t2_hold_valid[%0d]", i), 32'(sym_valid), 1);
      chk($sformatf("t2_hold_sym[%0d]", i),   32'(sym_out),   7);
      chk($sformatf("t2_hold_ready[%0d]", i), 32'(bit_ready), 0);
    end
    sym_ready = 1'b1;
    @(negedge clk);
    chk("t2_release_valid", 32'(sym_valid), 0);
    chk("t2_release_ready", 32'(bit_ready), 1);
    bit_valid = 1'b1; bit_in = 1'b0;
    @(negedge clk);
    bit_valid = 1'b0;
    chk("t2_next_valid", 32'(sym_valid), 1);
    chk("t2_next_sym",   32'(sym_out),   3);
    @(negedge clk);
    chk("t2_no_dup", 32'(sym_valid), 0);

    // T3: undecodable prefix 111... runs out of lengths
    cur_sz = t3_sz; cur_sy = t3_sy;
    do_load(cyc, err1);
    chk("t3_build_cycles", 32'(cyc), 17);
    for (int b = 0; b < 15; b++) begin
      @(negedge clk);
      chk($sformatf("t3_err_before[%0d]", b), 32'(err), 0);
      bit_valid = 1'b1;
      bit_in    = (b < 3);
    end
    @(negedge clk);
    bit_valid = 1'b1; bit_in = 1'b0;
    chk("t3_err_set",     32'(err),         1);
    chk("t3_ready_low",   32'(bit_ready),   0);
    chk("t3_table_low",   32'(table_ready), 0);
    repeat (3) @(negedge clk);
    bit_valid = 1'b0;
    chk("t3_err_sticky",  32'(err),         1);
    chk("t3_sym_quiet",   32'(sym_valid),   0);
    cur_sz = t1_sz; cur_sy = t1_sy;
    do_load(cyc, err1);
    chk("t3_err_cleared", 32'(err1), 0);
    chk("t3_rebuild_cycles", 32'(cyc), 17);

    // T4: all-zero table, then an over-long size
    cur_sz = '{default: 0}; cur_sy = t1_sy;
    do_load(cyc, err1);
    chk("t4_zero_err_cycle", 32'(cyc), 17);
    chk("t4_zero_err",       32'(err), 1);
    chk("t4_zero_table",     32'(table_ready), 0);
    cur_sz = t1_sz; cur_sz[15] = 16; cur_sy = t1_sy;
    do_load(cyc, err1);
    chk("t4_big_cleared",    32'(err1), 0);
    chk("t4_big_err_cycle",  32'(cyc), 17);
    chk("t4_big_err",        32'(err), 1);

    // T5: abort a half-received code with load (bit offered alongside load)
    cur_sz = t1_sz; cur_sy = t1_sy;
    do_load(cyc, err1);
    chk("t5_build_cycles", 32'(cyc), 17);
    @(negedge clk);
    bit_valid = 1'b1; bit_in = 1'b1;
    @(negedge clk);
    @(negedge clk);
    load = 1'b1; bit_in = 1'b0;
    @(negedge clk);
    load = 1'b0; bit_valid = 1'b0;
    cyc = 1;
    chk("t5_abort_table", 32'(table_ready), 0);
    chk("t5_abort_ready", 32'(bit_ready),   0);
    chk("t5_abort_valid", 32'(sym_valid),   0);
    while (!table_ready && !err && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    chk("t5_rebuild_cycles", 32'(cyc), 17);
    sym_ready = 1'b0; bit_valid = 1'b1; bit_in = 1'b0;
    @(negedge clk);
    bit_valid = 1'b0;
    chk("t5_fresh_valid", 32'(sym_valid), 1);
    chk("t5_fresh_sym",   32'(sym_out),   3);
    #2;
    reset_n = 1'b0;
    #1;
    chk("t5_reset_outputs", 32'({bit_ready, sym_valid, table_ready, err, sym_out}), 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("t5_post_reset", 32'({bit_ready, sym_valid, table_ready, err, sym_out}), 0);

    // T6: generator table, random stream encoded by an independent model
    cur_sz = t6_sz; cur_sy = t6_sy;
    begin
      int code, prev;
      code = 0; prev = 0;
      for (int i = 0; i < SYMBOLS; i++) begin
        if (t6_sz[i] != 0) begin
          code = code << (t6_sz[i] - prev);
          mcode[t6_sy[i]] = code;
          mlen[t6_sy[i]]  = t6_sz[i];
          used.push_back(t6_sy[i]);
          code++;
          prev = t6_sz[i];
        end
      end
    end
    for (int n = 0; n < 200; n++) begin
      int s;
      s = used[$urandom_range(0, used.size() - 1)];
      exp_q.push_back(s);
      for (int k = mlen[s] - 1; k >= 0; k--) bits.push_back(((mcode[s] >> k) & 1) != 0);
    end
    do_load(cyc, err1);
    chk("t6_build_cycles", 32'(cyc), 17);
    begin
      int ptr, rcv, ncyc;
      logic sr_now;
      ptr = 0; rcv = 0; ncyc = 0;
      while (rcv < 200 && ncyc < 20000) begin
        @(negedge clk);
        ncyc++;
        sr_now = ($urandom_range(0, 3) != 0);
        sym_ready = sr_now;
        if (sym_valid && sr_now) begin
          chk($sformatf("t6_sym[%0d]", rcv), 32'(sym_out), exp_q[rcv]);
          rcv++;
        end
        if (ptr < bits.size() && $urandom_range(0, 4) != 0) begin
          bit_valid = 1'b1;
          bit_in    = bits[ptr];
          if (bit_ready) ptr++;
        end else begin
          bit_valid = 1'b0;
        end
      end
      bit_valid = 1'b0;
      chk("t6_symbol_count", 32'(rcv), 200);
      chk("t6_bits_used",    32'(ptr), bits.size());
      chk("t6_err",          32'(err), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
